// File: rtl/opu_dispatcher.sv
// Round-robin request collector, request FIFO and single-outstanding issue FSM feeding the operation unit.
// Optional build macro DISPATCH_TIMEOUT_EN adds a WAIT-state watchdog that returns an error response.
module opu_dispatcher #(
    parameter int NUM_USERS  = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_USERS-1:0]          req_valid,
    output logic [NUM_USERS-1:0]          req_ready,
    input  logic [2*NUM_USERS-1:0]        req_op_code,
    input  logic [8*NUM_USERS-1:0]        req_data,
    output logic                          op_start,
    output logic [1:0]                    op_code,
    output logic [7:0]                    data_in,
    input  logic                          op_done,
    input  logic [7:0]                    data_out,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [$clog2(NUM_USERS)-1:0]  resp_user,
    output logic [7:0]                    resp_data,
    output logic                          resp_err,
    output logic                          busy
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid never waits for ready, and payload is held stable while valid is high and ready is low.

    localparam int USER_W  = $clog2(NUM_USERS);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = USER_W + 10;

    if (NUM_USERS < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 1)
    begin : g_bad_cfg
        $error("opu_dispatcher: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t state;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic [PTR_W:0]     count_nxt;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head;
    logic [USER_W-1:0]  head_user;
    logic [1:0]         head_op;
    logic [7:0]         head_data;

    assign fifo_full  = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign pop        = (state == S_IDLE) && !fifo_empty;
    assign head       = fifo_mem[rd_ptr];
    assign head_user  = head[ENTRY_W-1 -: USER_W];
    assign head_op    = head[9:8];
    assign head_data  = head[7:0];

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_entry;
        end
    end

    // ------------------------------------------------------------------
    // Round-robin arbitration; the grant is suppressed whenever the FIFO
    // is full, even if the FSM pops in the same cycle.
    // ------------------------------------------------------------------
    logic [USER_W-1:0]      rr_ptr;
    logic [USER_W-1:0]      grant_idx;
    logic                   grant_found;
    logic [2*NUM_USERS-1:0] valid_rot_wide;
    logic [NUM_USERS-1:0]   valid_rot;
    logic [2*NUM_USERS-1:0] op_sel_wide;
    logic [8*NUM_USERS-1:0] data_sel_wide;
    logic [USER_W-1:0]      rr_ptr_nxt;

    assign valid_rot_wide = {req_valid, req_valid} >> rr_ptr;
    assign valid_rot      = valid_rot_wide[NUM_USERS-1:0];

    always_comb begin : arb
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        if (!fifo_full) begin
            for (int i = 0; i < NUM_USERS; i++) begin
                if (!grant_found && valid_rot[i]) begin
                    grant_found = 1'b1;
                    idx         = int'(rr_ptr) + i;
                    if (idx >= NUM_USERS) begin
                        idx = idx - NUM_USERS;
                    end
                    grant_idx = USER_W'(idx);
                end
            end
        end
    end

    assign req_ready     = grant_found ? (NUM_USERS'(1) << grant_idx) : '0;
    assign push          = grant_found;
    assign op_sel_wide   = req_op_code >> {grant_idx, 1'b0};
    assign data_sel_wide = req_data >> {grant_idx, 3'b000};
    assign push_entry    = {grant_idx, op_sel_wide[1:0], data_sel_wide[7:0]};
    assign rr_ptr_nxt    = (grant_idx == USER_W'(NUM_USERS - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rr_ptr <= '0;
        end else begin
            count <= count_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= rr_ptr_nxt;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM with registered outputs
    // ------------------------------------------------------------------
    logic [USER_W-1:0] hold_user;
    logic              fsm_active_nxt;

    always_comb begin
        fsm_active_nxt = 1'b0;
        case (state)
            S_IDLE:  fsm_active_nxt = !fifo_empty;
            S_ISSUE: fsm_active_nxt = 1'b1;
            S_WAIT:  fsm_active_nxt = 1'b1;
            S_RESP:  fsm_active_nxt = !resp_ready;
            default: fsm_active_nxt = 1'b0;
        endcase
    end

`ifdef DISPATCH_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt;
`else
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            op_start   <= 1'b0;
            op_code    <= '0;
            data_in    <= '0;
            hold_user  <= '0;
            resp_valid <= 1'b0;
            resp_user  <= '0;
            resp_data  <= '0;
            busy       <= 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
            resp_err   <= 1'b0;
            tmo_cnt    <= '0;
`endif
        end else begin
            busy     <= fsm_active_nxt || (count_nxt != '0);
            op_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        state     <= S_ISSUE;
                        op_start  <= 1'b1;
                        op_code   <= head_op;
                        data_in   <= head_data;
                        hold_user <= head_user;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
`ifdef DISPATCH_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    // op_done wins over a timeout landing in the same cycle
                    if (op_done) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_user  <= hold_user;
                        resp_data  <= data_out;
`ifdef DISPATCH_TIMEOUT_EN
                        resp_err   <= 1'b0;
`endif
                    end
`ifdef DISPATCH_TIMEOUT_EN
                    else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_user  <= hold_user;
                        resp_data  <= 8'h00;
                        resp_err   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state      <= S_IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_opu_dispatcher.sv
// Directed bench for opu_dispatcher: single-cycle operation unit model, response monitor and queue scoreboard.
// Define DISPATCH_TIMEOUT_EN for both bench and RTL to include the watchdog scenario.
module tb_opu_dispatcher;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_op_code;
    logic [15:0] req_data;
    logic        op_start;
    logic [1:0]  op_code;
    logic [7:0]  data_in;
    logic        op_done;
    logic [7:0]  data_out;
    logic        resp_valid;
    logic        resp_ready;
    logic [0:0]  resp_user;
    logic [7:0]  resp_data;
    logic        resp_err;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit op_unit_en = 1'b1;
    bit force_done = 1'b0;
    bit pending    = 1'b0;
    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];

    opu_dispatcher #(.NUM_USERS(2), .FIFO_DEPTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op_code(req_op_code), .req_data(req_data),
        .op_start(op_start), .op_code(op_code), .data_in(data_in),
        .op_done(op_done), .data_out(data_out),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_user(resp_user), .resp_data(resp_data), .resp_err(resp_err),
        .busy(busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- operation unit model ----------------
    // op 00 pass, 01 shift left 2, 10 rotate right 2, 11 nibble swap
    function automatic logic [7:0] op_model(input logic [1:0] op, input logic [7:0] d);
        case (op)
            2'b00:   return d;
            2'b01:   return d << 2;
            2'b10:   return {d[1:0], d[7:2]};
            default: return {d[3:0], d[7:4]};
        endcase
    endfunction

    // op_done arrives one cycle after op_start, i.e. during the WAIT cycle
    always @(negedge clk) begin
        op_done  = force_done | (op_unit_en & pending);
        data_out = force_done ? 8'hEE : op_model(op_code, data_in);
        pending  = op_start;
    end

    // ---------------- response monitor ----------------
    always @(negedge clk) begin
        #2;
        if (resp_valid && resp_ready) got_q.push_back({resp_user, resp_data});
    end

    // ---------------- checking / driver tasks ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int u, input logic [1:0] op, input logic [7:0] d, input string tag);
        int  c;
        bit  got;
        c   = 0;
        got = 1'b0;
        req_valid = '0;
        req_valid[u] = 1'b1;
        req_op_code[2*u +: 2] = op;
        req_data[8*u +: 8] = d;
        #1;
        while (!got && c < 40) begin
            if (req_ready[u]) got = 1'b1;
            else begin
                @(negedge clk);
                #1;
                c++;
            end
        end
        check(tag, 32'(got), 32'd1);
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic wait_resp(input string tag);
        int c;
        c = 0;
        while (!resp_valid && c < 40) begin
            @(negedge clk);
            #1;
            c++;
        end
        check(tag, 32'(resp_valid), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        while (busy && c < 80) begin
            @(negedge clk);
            #1;
            c++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic check_queue(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- directed sequence ----------------
    initial begin
        time t0;
        rst = 1'b1;
        req_valid = '0;
        req_op_code = '0;
        req_data = '0;
        resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_op_start", 32'(op_start), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_resp_data", 32'(resp_data), 32'd0);
        rst = 1'b0;

        // --- two users in the same cycle, pointer at 0 ---
        @(negedge clk);
        resp_ready  = 1'b1;
        req_valid   = 2'b11;
        req_op_code = {2'b10, 2'b11};
        req_data    = {8'h03, 8'h0F};
        #1 check("rr_first", 32'(req_ready), 32'h1);
        @(negedge clk);
        #1 check("rr_second", 32'(req_ready), 32'h2);
        req_valid = 2'b10;
        @(negedge clk);
        req_valid = '0;
        wait_resp("rr_resp0_valid");
        check("rr_resp0_user", 32'(resp_user), 32'd0);
        check("rr_resp0_data", 32'(resp_data), 32'hF0);
        check("rr_resp0_err", 32'(resp_err), 32'd0);
        @(negedge clk);
        #1;
        wait_resp("rr_resp1_valid");
        check("rr_resp1_user", 32'(resp_user), 32'd1);
        check("rr_resp1_data", 32'(resp_data), 32'hC0);
        wait_idle("rr_idle");
        req_valid = 2'b11;
        #1 check("rr_ptr_back_to_0", 32'(req_ready), 32'h1);
        req_valid = '0;

        // --- single request latency ---
        @(negedge clk);
        req_valid = 2'b01;
        req_op_code = 4'b0001;
        req_data = 16'h0081;
        #1 check("lat_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("lat_t1_busy", 32'(busy), 32'd1);
        check("lat_t1_start", 32'(op_start), 32'd0);
        @(negedge clk);
        #1;
        check("lat_t2_start", 32'(op_start), 32'd1);
        check("lat_t2_op_code", 32'(op_code), 32'd1);
        check("lat_t2_data_in", 32'(data_in), 32'h81);
        @(negedge clk);
        #1;
        check("lat_t3_start", 32'(op_start), 32'd0);
        check("lat_t3_resp_valid", 32'(resp_valid), 32'd0);
        check("lat_t3_data_in", 32'(data_in), 32'h81);
        @(negedge clk);
        #1;
        check("lat_t4_resp_valid", 32'(resp_valid), 32'd1);
        check("lat_t4_resp_user", 32'(resp_user), 32'd0);
        check("lat_t4_resp_data", 32'(resp_data), 32'h04);
        check("lat_t4_resp_err", 32'(resp_err), 32'd0);
        @(negedge clk);
        #1;
        check("lat_t5_resp_valid", 32'(resp_valid), 32'd0);
        check("lat_t5_busy", 32'(busy), 32'd0);

        // --- FIFO fill with response stalled ---
        got_q.delete();
        exp_q.delete();
        @(negedge clk);
        resp_ready = 1'b0;
        for (int k = 1; k <= 5; k++) send(0, 2'b00, 8'(k), $sformatf("fill_send_%0d", k));
        req_valid = 2'b01;
        req_op_code = 4'b0000;
        req_data = 16'h0006;
        for (int k = 0; k < 5; k++) begin
            #1 check("fill_stall_ready", 32'(req_ready), 32'h0);
            @(negedge clk);
        end
        #1;
        check("fill_stall_resp_valid", 32'(resp_valid), 32'd1);
        check("fill_stall_resp_data", 32'(resp_data), 32'h01);
        check("fill_stall_busy", 32'(busy), 32'd1);
        resp_ready = 1'b1;
        send(0, 2'b00, 8'h06, "fill_send_6");
        send(0, 2'b00, 8'h07, "fill_send_7");
        wait_idle("fill_idle");
        for (int k = 1; k <= 7; k++) exp_q.push_back({1'b0, 8'(k)});
        check_queue("fill_order");

        // --- response held under backpressure ---
        got_q.delete();
        exp_q.delete();
        resp_ready = 1'b0;
        send(1, 2'b11, 8'hA5, "hold_send_a");
        wait_resp("hold_resp_valid");
        send(0, 2'b00, 8'h33, "hold_send_b");
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_user", 32'(resp_user), 32'd1);
            check("hold_data", 32'(resp_data), 32'h5A);
            check("hold_no_issue", 32'(op_start), 32'd0);
        end
        resp_ready = 1'b1;
        wait_idle("hold_idle");
        exp_q.push_back({1'b1, 8'h5A});
        exp_q.push_back({1'b0, 8'h33});
        check_queue("hold_order");

        // --- reset while waiting with two requests queued ---
        got_q.delete();
        exp_q.delete();
        op_unit_en = 1'b0;
        send(0, 2'b01, 8'h11, "rstw_send_a");
        send(1, 2'b01, 8'h22, "rstw_send_b");
        send(0, 2'b01, 8'h33, "rstw_send_c");
        #1;
        check("rstw_busy_before", 32'(busy), 32'd1);
        check("rstw_data_in_before", 32'(data_in), 32'h11);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rstw_op_start", 32'(op_start), 32'd0);
        check("rstw_op_code", 32'(op_code), 32'd0);
        check("rstw_data_in", 32'(data_in), 32'd0);
        check("rstw_resp_valid", 32'(resp_valid), 32'd0);
        check("rstw_resp_user", 32'(resp_user), 32'd0);
        check("rstw_resp_data", 32'(resp_data), 32'd0);
        check("rstw_resp_err", 32'(resp_err), 32'd0);
        check("rstw_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        force_done = 1'b1;
        @(negedge clk);
        #1 force_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            check("rstw_quiet_valid", 32'(resp_valid), 32'd0);
            check("rstw_quiet_busy", 32'(busy), 32'd0);
            check("rstw_quiet_start", 32'(op_start), 32'd0);
        end
        check("rstw_no_resp", 32'(got_q.size()), 32'd0);
        op_unit_en = 1'b1;
        send(1, 2'b10, 8'h0C, "rstw_post_send");
        wait_resp("rstw_post_valid");
        check("rstw_post_user", 32'(resp_user), 32'd1);
        check("rstw_post_data", 32'(resp_data), 32'h03);
        wait_idle("rstw_post_idle");

`ifdef DISPATCH_TIMEOUT_EN
        // --- watchdog: operation unit never answers ---
        got_q.delete();
        exp_q.delete();
        op_unit_en = 1'b0;
        send(0, 2'b01, 8'h55, "tmo_send_x");
        begin
            int c;
            c = 0;
            #1;
            while (!op_start && c < 20) begin
                @(negedge clk);
                #1;
                c++;
            end
            check("tmo_issue", 32'(op_start), 32'd1);
        end
        t0 = $time;
        send(1, 2'b11, 8'h3C, "tmo_send_y");
        wait_resp("tmo_resp_valid");
        check("tmo_latency", 32'(($time - t0) / 10), 32'd17);
        check("tmo_resp_err", 32'(resp_err), 32'd1);
        check("tmo_resp_data", 32'(resp_data), 32'h00);
        check("tmo_resp_user", 32'(resp_user), 32'd0);
        op_unit_en = 1'b1;
        @(negedge clk);
        #1;
        wait_resp("tmo_next_valid");
        check("tmo_next_err", 32'(resp_err), 32'd0);
        check("tmo_next_data", 32'(resp_data), 32'hC3);
        wait_idle("tmo_idle");
        exp_q.push_back({1'b0, 8'h00});
        exp_q.push_back({1'b1, 8'hC3});
        check_queue("tmo_order");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/opu_dispatcher.md
Name: opu_dispatcher

Overview:
Upstream stage of the operation unit. Collects operation requests from NUM_USERS user ports and arbitrates them round-robin into a shared request FIFO. Issues one request at a time to the operation unit over op_start/op_code/data_in, waits for op_done, and returns the result on a tagged response channel with valid/ready backpressure.

Parameters:
NUM_USERS, 2, number of user request ports (>=2); USER_W = clog2(NUM_USERS) derived localparam
FIFO_DEPTH, 4, request FIFO entries (power of 2, >=2)
TIMEOUT, 16, max cycles in WAIT before error response (used only with DISPATCH_TIMEOUT_EN)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  NUM_USERS  per-user request valid
req_ready  output  NUM_USERS  per-user accept (at most one bit high)
req_op_code  input  2*NUM_USERS  per-user op code, user k at [2k+1:2k]
req_data  input  8*NUM_USERS  per-user operand, user k at [8k+7:8k]
op_start  output  1  one-cycle pulse to operation unit
op_code  output  2  op code to operation unit
data_in  output  8  operand to operation unit
op_done  input  1  completion pulse from operation unit
data_out  input  8  result, valid in op_done cycle
resp_valid  output  1  response valid
resp_ready  input  1  response accept
resp_user  output  USER_W  originating user index
resp_data  output  8  result
resp_err  output  1  timeout error flag
busy  output  1  FSM not IDLE or FIFO non-empty

Behaviour:
- Reset (rst=1 at clk edge): op_start, op_code, data_in, resp_valid, resp_user, resp_data, resp_err, busy = 0. FIFO emptied. RR pointer = 0. FSM = IDLE. Reset mid-operation discards in-flight and queued requests. A late op_done after reset is ignored.
- Arbitration (combinational req_ready):
  - If FIFO not full, grant the first valid user scanning from the RR pointer upward, mod NUM_USERS.
  - req_ready is one-hot to that user, else all zero.
  - Push {user, op_code, data} when req_valid & req_ready.
  - After a grant to user k, pointer = (k+1) mod NUM_USERS; no grant leaves the pointer unchanged.
- FIFO full: all req_ready = 0 even if a pop occurs the same cycle. Simultaneous push and pop when not full is allowed and count is unchanged.
- FSM (states IDLE, ISSUE, WAIT, RESP):
  - IDLE: if FIFO non-empty, pop the head into the hold register and go to ISSUE.
  - ISSUE: op_start=1 for exactly this cycle; op_code/data_in driven from the hold register; go to WAIT.
  - WAIT: op_code/data_in held stable. On op_done, capture data_out into resp_data, set resp_user, resp_err=0, go to RESP.
  - RESP: resp_valid=1 with resp_user/resp_data/resp_err stable until resp_valid & resp_ready, then resp_valid=0 and go to IDLE.
- op_done outside WAIT is ignored.
- All outputs except req_ready are registered.
- Latency: request accepted at edge t -> op_start high in cycle t+2 -> op_done at t+3 (single-cycle operation unit) -> resp_valid in cycle t+4.
- Throughput: one request per 4 cycles with resp_ready held high.
- Per-user order is preserved; cross-user order is FIFO acceptance order.

Optional Feature:
DISPATCH_TIMEOUT_EN
- Defined: a counter is cleared on WAIT entry and increments each WAIT cycle. If it reaches TIMEOUT without op_done, go to RESP with resp_err=1 and resp_data=0x00. op_done in the same cycle as the timeout takes priority (normal response).
- Undefined: no counter; WAIT holds until op_done; resp_err tied 0.

Test Plan:
- User0 op 2'b01 data 0x81, resp_ready=1, paired with the operation unit model -> op_start in cycle t+2; resp_valid in cycle t+4 with resp_user=0, resp_data=0x04, resp_err=0.
- User0 (op 2'b11, 0x0F) and user1 (op 2'b10, 0x03) valid in the same cycle, pointer=0 -> user0 accepted first, user1 next cycle. Responses in order: user0 0xF0, then user1 0xC0. Pointer ends at 0.
- resp_ready=0, user0 streams op 2'b00 with data 0x01..0x07 -> 1 request in RESP plus 4 queued; 6th request stalls with req_ready=0. Raise resp_ready -> responses 0x01..0x05 in order, then remaining requests accepted.
- resp_ready held low 10 cycles in RESP -> resp_valid, resp_user, resp_data stable throughout; single handshake; FIFO pop only after return to IDLE.
- Assert rst for one cycle while in WAIT with 2 entries queued -> all outputs 0, busy=0; subsequent op_done ignored; no response emitted.
- DISPATCH_TIMEOUT_EN, TIMEOUT=16, operation unit model never asserts op_done -> resp_valid 16 cycles after WAIT entry with resp_err=1, resp_data=0x00; next queued request then issues normally.
